pipeline_stall_controller: RTL and testbench

- Central sequencer for the 5-stage pipeline. Merges three event sources into one consistent set of per-stage write enables and flush/bubble controls:
  - load-use hazard flag from ID;
  - taken-branch redirect from EX;
  - multi-cycle data-memory handshake from MEM.
- Owns the memory-wait state machine, a memory timeout watchdog and two saturating performance counters.

---
 rtl/pipeline_ctrl_pkg.sv | 44 ++++
 rtl/pipeline_stall_controller_sat_counter.sv | 16 +
 rtl/pipeline_stall_controller.sv | 102 ++++++++++
 tb/tb_pipeline_stall_controller.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall controller: FSM states, default
// watchdog limit and the bit ordering of the per-stage control bundle.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam int MEM_TIMEOUT_DEF = 200;

  // MSB-first ordering is what the pipeline top unpacks.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic mem_wb_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE   = '0;
  localparam ctrl_t CTRL_FREEZE = 8'b0000_1001;

  // Normal-flow controls; a taken branch squashes the load-use stall since
  // the stalled instruction is on the wrong path.
  function automatic ctrl_t run_ctrl(input logic branch, input logic hazard);
    ctrl_t c;
    c = 8'b1111_1000;
    if (branch) begin
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (hazard) begin
      c.pc_write    = 1'b0;
      c.if_id_write = 1'b0;
      c.id_ex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge arst) begin
    if (arst)                     count <= '0;
    else if (inc && count != '1)  count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline: memory-wait FSM,
// timeout watchdog and stall/flush performance counters.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             load_use_hazard,
  input  logic             branch_taken_ex,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [TO_W:0] TO_LIM = MEM_TIMEOUT[TO_W:0];

  state_e          state, state_n;
  logic [TO_W-1:0] wait_cnt, wait_n;
  logic [TO_W:0]   wait_inc;
  ctrl_t           ctrl;
  logic            flush_inc, stall_inc, stuck;

  // A dropped request while waiting is treated as completion.
  assign stuck    = dmem_req && !dmem_ready;
  assign wait_inc = {1'b0, wait_cnt} + 1'b1;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
    end
  end

  always_comb begin
    state_n   = state;
    wait_n    = wait_cnt;
    ctrl      = CTRL_IDLE;
    flush_inc = 1'b0;
    case (state)
      RUN: begin
        if (stuck) begin
          ctrl    = CTRL_FREEZE;
          state_n = (MEM_TIMEOUT == 1) ? ERROR : MEM_WAIT;
          wait_n  = {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
          ctrl      = run_ctrl(branch_taken_ex, load_use_hazard);
          flush_inc = branch_taken_ex;
        end
      end
      MEM_WAIT: begin
        if (stuck) begin
          ctrl   = CTRL_FREEZE;
          wait_n = wait_inc[TO_W-1:0];
          if (wait_inc >= TO_LIM) state_n = ERROR;
        end else begin
          ctrl      = run_ctrl(branch_taken_ex, load_use_hazard);
          flush_inc = branch_taken_ex;
          state_n   = RUN;
          wait_n    = '0;
        end
      end
      ERROR:   ctrl = CTRL_IDLE;
      default: state_n = RUN;
    endcase
    if (arst) begin
      ctrl      = CTRL_IDLE;
      flush_inc = 1'b0;
    end
  end

  assign stall_inc = !ctrl.pc_write && !arst;

  assign {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
          if_id_flush, id_ex_flush, mem_wb_bubble} = ctrl;
  assign mem_timeout_err = (state == ERROR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .arst(arst), .inc(stall_inc), .count(stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .arst(arst), .inc(flush_inc), .count(flush_count)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (CNT_W=4, MEM_TIMEOUT=4).
module tb_pipeline_stall_controller;

  logic       clk = 1'b0;
  logic       arst;
  logic       load_use_hazard, branch_taken_ex, dmem_req, dmem_ready;
  logic       pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic       if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout_err;
  logic [3:0] stall_cycles, flush_count;
  logic [7:0] ctrl;

  int checks   = 0;
  int failures = 0;

  pipeline_stall_controller #(.CNT_W(4), .TO_W(8), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .arst(arst),
    .load_use_hazard(load_use_hazard), .branch_taken_ex(branch_taken_ex),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_bubble(mem_wb_bubble), .mem_timeout_err(mem_timeout_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  assign ctrl = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                 if_id_flush, id_ex_flush, mem_wb_bubble};

  localparam logic [7:0] C_RUN    = 8'hF8;
  localparam logic [7:0] C_LU     = 8'h3A;
  localparam logic [7:0] C_BR     = 8'hFE;
  localparam logic [7:0] C_FREEZE = 8'h09;
  localparam logic [7:0] C_NONE   = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lu, input logic br, input logic req, input logic rdy);
    load_use_hazard = lu;
    branch_taken_ex = br;
    dmem_req        = req;
    dmem_ready      = rdy;
    #1;
  endtask

  initial begin
    arst = 1'b1;
    drive(0, 0, 0, 0);
    chk("rst_ctrl", {24'd0, ctrl}, {24'd0, C_NONE});
    chk("rst_err", {31'd0, mem_timeout_err}, 32'd0);
    tick(); tick();
    chk("rst_stall", {28'd0, stall_cycles}, 32'd0);
    arst = 1'b0;
    #1;
    chk("run_ctrl", {24'd0, ctrl}, {24'd0, C_RUN});
    tick();

    // single-cycle load-use stall
    drive(1, 0, 0, 0);
    chk("lu_ctrl", {24'd0, ctrl}, {24'd0, C_LU});
    tick();
    drive(0, 0, 0, 0);
    chk("lu_release", {24'd0, ctrl}, {24'd0, C_RUN});
    chk("lu_stall", {28'd0, stall_cycles}, 32'd1);

    // branch beats load-use
    drive(1, 1, 0, 0);
    chk("br_lu_ctrl", {24'd0, ctrl}, {24'd0, C_BR});
    tick();
    drive(0, 0, 0, 0);
    chk("br_flush", {28'd0, flush_count}, 32'd1);
    chk("br_stall", {28'd0, stall_cycles}, 32'd1);

    // asynchronous reset pulse mid-run
    arst = 1'b1;
    #1;
    chk("arst_ctrl", {24'd0, ctrl}, {24'd0, C_NONE});
    chk("arst_stall", {28'd0, stall_cycles}, 32'd0);
    chk("arst_flush", {28'd0, flush_count}, 32'd0);
    arst = 1'b0;
    tick();
    chk("post_rst_ctrl", {24'd0, ctrl}, {24'd0, C_RUN});
    chk("post_rst_err", {31'd0, mem_timeout_err}, 32'd0);

    // 3 freeze cycles with a pending branch, branch applied on ready cycle
    drive(0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("freeze%0d_ctrl", i), {24'd0, ctrl}, {24'd0, C_FREEZE});
      tick();
    end
    drive(0, 1, 1, 1);
    chk("ready_br_ctrl", {24'd0, ctrl}, {24'd0, C_BR});
    tick();
    drive(0, 0, 0, 0);
    chk("mem_stall", {28'd0, stall_cycles}, 32'd3);
    chk("mem_flush", {28'd0, flush_count}, 32'd1);
    chk("mem_back_run", {24'd0, ctrl}, {24'd0, C_RUN});

    // ready on the cycle the watchdog would fire: completes, no error
    drive(0, 0, 1, 0);
    tick(); tick(); tick();
    drive(0, 0, 1, 1);
    chk("edge_ready_ctrl", {24'd0, ctrl}, {24'd0, C_RUN});
    tick();
    drive(0, 0, 0, 0);
    chk("edge_no_err", {31'd0, mem_timeout_err}, 32'd0);
    chk("edge_stall", {28'd0, stall_cycles}, 32'd6);

    // dropped request while waiting behaves as ready
    drive(0, 0, 1, 0);
    tick();
    drive(1, 0, 0, 0);
    chk("drop_req_ctrl", {24'd0, ctrl}, {24'd0, C_LU});
    tick();
    drive(0, 0, 0, 0);
    chk("drop_req_run", {24'd0, ctrl}, {24'd0, C_RUN});
    chk("drop_req_stall", {28'd0, stall_cycles}, 32'd8);

    // watchdog timeout after 4 wait cycles
    drive(0, 0, 1, 0);
    tick(); tick(); tick();
    chk("to_pre_err", {31'd0, mem_timeout_err}, 32'd0);
    chk("to_pre_ctrl", {24'd0, ctrl}, {24'd0, C_FREEZE});
    tick();
    chk("to_err", {31'd0, mem_timeout_err}, 32'd1);
    chk("to_ctrl", {24'd0, ctrl}, {24'd0, C_NONE});
    chk("to_stall", {28'd0, stall_cycles}, 32'd12);
    drive(1, 1, 1, 1);
    chk("err_ignore_ctrl", {24'd0, ctrl}, {24'd0, C_NONE});
    tick();
    chk("err_sticky", {31'd0, mem_timeout_err}, 32'd1);
    chk("err_stall", {28'd0, stall_cycles}, 32'd13);
    chk("err_flush", {28'd0, flush_count}, 32'd1);
    drive(0, 0, 0, 0);
    arst = 1'b1;
    #1;
    chk("err_clr", {31'd0, mem_timeout_err}, 32'd0);
    arst = 1'b0;
    tick();

    // stall counter saturation
    drive(1, 0, 0, 0);
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", {28'd0, stall_cycles}, 32'd14);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_15", {28'd0, stall_cycles}, 32'd15);
    drive(0, 0, 0, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
